// File: rtl/pipe_hazard_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared types and constants for the pipeline stall/flush sequencer.
//   state_t : sequencer state (RUN / MDU_WAIT)
//   ctrl_t  : bundle of every pause/flush control the sequencer drives
//   REG_AW_DEF, X0 : register-index width default and the hard-wired zero
//                    register index
// ----------------------------------------------------------------------------
package pipe_ctrl_pkg;

    localparam int REG_AW_DEF = 5;
    localparam int X0         = 0;

    typedef enum logic {
        RUN      = 1'b0,
        MDU_WAIT = 1'b1
    } state_t;

    // All controls the sequencer drives, in one place so the priority logic
    // can clear them with a single default assignment.
    typedef struct packed {
        logic pc_pause;
        logic pc_flush;
        logic ifid_pause;
        logic ifid_flush;
        logic idex_pause;
        logic idex_flush;
        logic exmem_flush;
        logic mdu_busy;
    } ctrl_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// ----------------------------------------------------------------------------
// pipe_hazard_ctrl_if
// Hazard information from the ID/EX stages and the pause/flush controls
// going back to the PC and pipeline registers.
//   modport master : pipeline datapath side (drives hazard info, receives
//                    controls)
//   modport slave  : sequencer side (pipe_hazard_ctrl)
// Optional macro PIPE_HAZARD_PERF_EN adds perf_stall_cyc / perf_flush_cnt.
// ----------------------------------------------------------------------------
interface pipe_hazard_ctrl_if
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF
) ();

    // Hazard information
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_rs1_used;
    logic              id_rs2_used;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_memread;
    logic              ex_redirect;
    logic              ex_mdu_start;

    // Controls
    logic pc_pause;
    logic pc_flush;
    logic ifid_pause;
    logic ifid_flush;
    logic idex_pause;
    logic idex_flush;
    logic exmem_flush;
    logic mdu_busy;

`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] perf_stall_cyc;
    logic [31:0] perf_flush_cnt;
`endif

    modport master (
        output id_rs1, id_rs2, id_rs1_used, id_rs2_used,
        output ex_rd, ex_memread, ex_redirect, ex_mdu_start,
        input  pc_pause, pc_flush, ifid_pause, ifid_flush,
        input  idex_pause, idex_flush, exmem_flush, mdu_busy
`ifdef PIPE_HAZARD_PERF_EN
        ,
        input  perf_stall_cyc, perf_flush_cnt
`endif
    );

    modport slave (
        input  id_rs1, id_rs2, id_rs1_used, id_rs2_used,
        input  ex_rd, ex_memread, ex_redirect, ex_mdu_start,
        output pc_pause, pc_flush, ifid_pause, ifid_flush,
        output idex_pause, idex_flush, exmem_flush, mdu_busy
`ifdef PIPE_HAZARD_PERF_EN
        ,
        output perf_stall_cyc, perf_flush_cnt
`endif
    );

endinterface

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// ----------------------------------------------------------------------------
// hazard_detect
// Combinational load-use compare: flags when the load in EX writes a register
// that the instruction in ID reads. Loads to x0 never hazard.
//   id_rs1, id_rs2           : ID source register indices
//   id_rs1_used, id_rs2_used : ID actually reads that source
//   ex_rd, ex_memread        : EX destination and "is a load"
//   lu                       : load-use hazard present
// ----------------------------------------------------------------------------
module hazard_detect
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_memread,
    output logic              lu
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit = id_rs1_used && (id_rs1 == ex_rd);
    assign rs2_hit = id_rs2_used && (id_rs2 == ex_rd);
    assign lu      = ex_memread && (ex_rd != REG_AW'(X0)) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Central stall/flush sequencer for the 5-stage pipeline. Resolves, in
// priority order: EX redirects, multi-cycle MDU holds, and load-use bubbles.
// Controls are combinational from state and inputs; rst low forces them all
// to 0.
//   clk  : pipeline clock
//   rst  : synchronous active-low reset
//   bus  : pipe_hazard_ctrl_if.slave (hazard info in, pause/flush out)
// Parameters:
//   MDU_LAT : total cycles an MDU op occupies EX (2..16)
//   REG_AW  : register-index width
// Optional macro PIPE_HAZARD_PERF_EN adds registered stall/flush counters.
// ----------------------------------------------------------------------------
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MDU_LAT = 4,
    parameter int REG_AW  = REG_AW_DEF
) (
    input  logic                clk,
    input  logic                rst,
    pipe_hazard_ctrl_if.slave   bus
);

    localparam int              CNT_W    = $clog2(MDU_LAT);
    // The entry cycle is spent in RUN, so the wait covers MDU_LAT-1 cycles
    // and the counter runs MDU_LAT-2 .. 0.
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MDU_LAT - 2);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    ctrl_t            ctrl;
    logic             lu;
    logic             mdu_defer;

    hazard_detect #(
        .REG_AW (REG_AW)
    ) u_hazard_detect (
        .id_rs1      (bus.id_rs1),
        .id_rs2      (bus.id_rs2),
        .id_rs1_used (bus.id_rs1_used),
        .id_rs2_used (bus.id_rs2_used),
        .ex_rd       (bus.ex_rd),
        .ex_memread  (bus.ex_memread),
        .lu          (lu)
    );

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // An MDU op entering EX alongside a redirect is the older instruction;
    // the redirect waits until EX is released and presents it again.
    assign mdu_defer = (state == RUN) && bus.ex_mdu_start;

    always_comb begin
        // NOTE: every output of this block is defaulted first so no path
        // leaves one unassigned and infers a latch.
        ctrl      = '0;
        state_nxt = state;
        cnt_nxt   = cnt;

        if (!rst) begin
            // Everything held at 0; the flops are cleared by the register.
            state_nxt = RUN;
            cnt_nxt   = '0;
        end else if (bus.ex_redirect && !mdu_defer) begin
            ctrl.pc_flush   = 1'b1;
            ctrl.ifid_flush = 1'b1;
            ctrl.idex_flush = 1'b1;
            state_nxt       = RUN;
            cnt_nxt         = '0;
        end else if (mdu_defer) begin
            ctrl.pc_pause    = 1'b1;
            ctrl.ifid_pause  = 1'b1;
            ctrl.idex_pause  = 1'b1;
            ctrl.exmem_flush = 1'b1;
            state_nxt        = MDU_WAIT;
            cnt_nxt          = CNT_INIT;
        end else if (state == MDU_WAIT) begin
            ctrl.pc_pause    = 1'b1;
            ctrl.ifid_pause  = 1'b1;
            ctrl.idex_pause  = 1'b1;
            ctrl.exmem_flush = 1'b1;
            ctrl.mdu_busy    = 1'b1;
            if (cnt == '0) begin
                state_nxt = RUN;
            end else begin
                cnt_nxt = cnt - 1'b1;
            end
        end else if (lu) begin
            // One bubble: the load moves to MEM next cycle and lu clears.
            ctrl.pc_pause   = 1'b1;
            ctrl.ifid_pause = 1'b1;
            ctrl.idex_flush = 1'b1;
        end
    end

    assign bus.pc_pause    = ctrl.pc_pause;
    assign bus.pc_flush    = ctrl.pc_flush;
    assign bus.ifid_pause  = ctrl.ifid_pause;
    assign bus.ifid_flush  = ctrl.ifid_flush;
    assign bus.idex_pause  = ctrl.idex_pause;
    assign bus.idex_flush  = ctrl.idex_flush;
    assign bus.exmem_flush = ctrl.exmem_flush;
    assign bus.mdu_busy    = ctrl.mdu_busy;

`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] perf_stall_cyc;
    logic [31:0] perf_flush_cnt;

    // Free-running, wrap at 2^32.
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_stall_cyc <= '0;
            perf_flush_cnt <= '0;
        end else begin
            perf_stall_cyc <= perf_stall_cyc + 32'(ctrl.pc_pause);
            perf_flush_cnt <= perf_flush_cnt + 32'(ctrl.pc_flush);
        end
    end

    assign bus.perf_stall_cyc = perf_stall_cyc;
    assign bus.perf_flush_cnt = perf_flush_cnt;
`endif

    // EX is frozen during an MDU wait, so a redirect there is a pipeline bug.
    a_no_redirect_in_wait : assert property (
        @(posedge clk) disable iff (!rst) !(state == MDU_WAIT && bus.ex_redirect)
    );

    a_pc_excl : assert property (
        @(posedge clk) !(ctrl.pc_pause && ctrl.pc_flush)
    );

    a_ifid_excl : assert property (
        @(posedge clk) !(ctrl.ifid_pause && ctrl.ifid_flush)
    );

endmodule
